packed_lane_adder: RTL and testbench

- Multi-lane FIFO-to-FIFO adder, successor to the single 4-bit adder stage in the CL user logic.
- Each input word carries LANES operand pairs of OPERAND_WIDTH bits, added in parallel in a selectable wide or saturating mode.
- Fully pipelined at one word per cycle, with a credit-limited result buffer so output back-pressure never drops a result.
- Sits between the host input FIFO (first-word-fall-through) and the host output FIFO; exposes completion and overflow counters.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/lane_adder.sv | 53 +++++
 rtl/packed_lane_adder.sv | 144 ++++++++++++++
 tb/tb_packed_lane_adder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared defaults and elaboration helpers for the packed lane adder.
package adder_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_OPERAND_WIDTH = 4;
    localparam int DEF_LANES         = 4;
    localparam int DEF_RESULT_DEPTH  = 4;
    localparam int DEF_CNT_WIDTH     = 16;

    // Width of one packed result lane: wide sums keep the carry, saturated ones do not.
    function automatic int out_lane_w(input int ow, input bit sat);
        return sat ? ow : ow + 1;
    endfunction

    function automatic bit params_ok(input int dw, input int ow, input int lanes, input int depth);
        return (ow >= 1) && (lanes >= 1) && (depth >= 1) &&
               (2 * lanes * ow <= dw) &&
               (lanes * out_lane_w(ow, 1'b0) <= dw);
    endfunction

endpackage

// File: rtl/lane_adder.sv
// Stage S2: parallel lane adders with wide/saturating packing and a per-word overflow flag.
module lane_adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
    parameter int LANES         = DEF_LANES
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               in_valid,
    input  logic [2*LANES*OPERAND_WIDTH-1:0]   operands,
    input  logic                               sat_mode,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              result,
    output logic                               overflow
);

    localparam int OW     = OPERAND_WIDTH;
    localparam int WIDE_W = out_lane_w(OW, 1'b0);
    localparam int SAT_W  = out_lane_w(OW, 1'b1);

    logic [OW:0]           lane_sum [LANES];
    logic [DATA_WIDTH-1:0] packed_next;
    logic                  ovf_next;

    always_comb begin
        packed_next = '0;
        ovf_next    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum[i] = {1'b0, operands[2*i*OW +: OW]} + {1'b0, operands[(2*i+1)*OW +: OW]};
            ovf_next    = ovf_next | lane_sum[i][OW];
            if (sat_mode) begin
                packed_next[i*SAT_W +: SAT_W] = lane_sum[i][OW] ? {SAT_W{1'b1}} : lane_sum[i][SAT_W-1:0];
            end else begin
                packed_next[i*WIDE_W +: WIDE_W] = lane_sum[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            result    <= packed_next;
            overflow  <= in_valid & ovf_next;
        end
    end

endmodule

// File: rtl/packed_lane_adder.sv
// FIFO-to-FIFO multi-lane adder: operand stage, lane adders, credit-limited result buffer,
// registered output and status counters.
module packed_lane_adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
    parameter int LANES         = DEF_LANES,
    parameter int RESULT_DEPTH  = DEF_RESULT_DEPTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  data_empty,
    output logic                  data_rd,
    input  logic [DATA_WIDTH-1:0] data_din,
    input  logic                  data_full,
    output logic                  data_wr,
    output logic [DATA_WIDTH-1:0] data_dout,
    input  logic                  sat_mode,
    input  logic                  clear_counts,
    output logic [CNT_WIDTH-1:0]  words_done,
    output logic [CNT_WIDTH-1:0]  ovf_words,
    output logic                  busy
);

    localparam int OPW   = 2 * LANES * OPERAND_WIDTH;
    localparam int PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
    localparam int OCC_W = $clog2(RESULT_DEPTH + 3);

    generate
        if (!params_ok(DATA_WIDTH, OPERAND_WIDTH, LANES, RESULT_DEPTH)) begin : g_bad_params
            $error("packed_lane_adder: illegal parameter combination");
        end
    endgenerate

    logic                  s1_valid;
    logic [OPW-1:0]        s1_operands;
    logic                  s1_sat;
    logic                  s2_valid;
    logic                  s2_ovf;
    logic [DATA_WIDTH-1:0] s2_result;

    logic [DATA_WIDTH-1:0] result_mem [RESULT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occupancy;
    logic [OCC_W-1:0]      credit_used;
    logic                  buf_nonempty;
    logic                  out_fire;
    logic                  bypass;
    logic                  buf_write;
    logic                  buf_read;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c,
                                                  input logic inc, input logic clr);
        if (clr) return '0;
        if (inc && (c != {CNT_WIDTH{1'b1}})) return c + CNT_WIDTH'(1);
        return c;
    endfunction

    // Every word past the pop owns a buffer slot, so the S2 result always has somewhere to go.
    assign credit_used  = occupancy + OCC_W'(s1_valid) + OCC_W'(s2_valid);
    assign data_rd      = reset_n & ~data_empty & (credit_used < OCC_W'(RESULT_DEPTH));
    assign buf_nonempty = (occupancy != '0);
    assign out_fire     = ~data_full & (buf_nonempty | s2_valid);
    assign bypass       = out_fire & ~buf_nonempty;
    assign buf_write    = s2_valid & ~bypass;
    assign buf_read     = out_fire & buf_nonempty;
    assign busy         = s1_valid | s2_valid | buf_nonempty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_operands <= '0;
            s1_sat      <= 1'b0;
        end else begin
            s1_valid <= data_rd;
            if (data_rd) begin
                s1_operands <= data_din[OPW-1:0];
                s1_sat      <= sat_mode;
            end
        end
    end

    lane_adder #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPERAND_WIDTH (OPERAND_WIDTH),
        .LANES         (LANES)
    ) u_lane_adder (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (s1_valid),
        .operands  (s1_operands),
        .sat_mode  (s1_sat),
        .out_valid (s2_valid),
        .result    (s2_result),
        .overflow  (s2_ovf)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (buf_write) wr_ptr <= next_ptr(wr_ptr);
            if (buf_read)  rd_ptr <= next_ptr(rd_ptr);
            occupancy <= occupancy + OCC_W'(buf_write) - OCC_W'(buf_read);
        end
    end

    always_ff @(posedge clock) begin
        if (buf_write) result_mem[wr_ptr] <= s2_result;
    end

    // With an empty buffer the S2 result goes straight to the output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_wr   <= 1'b0;
            data_dout <= '0;
        end else if (out_fire) begin
            data_wr   <= 1'b1;
            data_dout <= buf_nonempty ? result_mem[rd_ptr] : s2_result;
        end else begin
            data_wr   <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            words_done <= '0;
            ovf_words  <= '0;
        end else begin
            words_done <= bump(words_done, out_fire, clear_counts);
            ovf_words  <= bump(ovf_words, s2_valid & s2_ovf, clear_counts);
        end
    end

endmodule

// File: tb/tb_packed_lane_adder.sv
// Self-checking bench for packed_lane_adder: FWFT source model, result scoreboard, directed and random traffic.
module tb_packed_lane_adder;

    localparam int DW    = 32;
    localparam int OW    = 4;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    typedef struct {
        logic [DW-1:0] word;
        bit            sat;
    } src_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          data_empty = 1'b1;
    logic          data_rd;
    logic [DW-1:0] data_din = '0;
    logic          data_full = 1'b0;
    logic          data_wr;
    logic [DW-1:0] data_dout;
    logic          sat_mode = 1'b0;
    logic          clear_counts = 1'b0;
    logic [CW-1:0] words_done;
    logic [CW-1:0] ovf_words;
    logic          busy;

    src_t          src_q[$];
    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            pops = 0;
    int            pushed = 0;
    int            exp_ovf = 0;
    int            exp_done = 0;
    int            rd_gap = 0;
    bit            pop_pending = 0;
    bit            lat_en = 0;
    bit            stream_chk = 0;
    bit            full_hold = 0;
    bit            full_rand = 0;
    logic [DW-1:0] last_dout = '0;

    packed_lane_adder #(
        .DATA_WIDTH    (DW),
        .OPERAND_WIDTH (OW),
        .LANES         (LANES),
        .RESULT_DEPTH  (DEPTH),
        .CNT_WIDTH     (CW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .data_empty   (data_empty),
        .data_rd      (data_rd),
        .data_din     (data_din),
        .data_full    (data_full),
        .data_wr      (data_wr),
        .data_dout    (data_dout),
        .sat_mode     (sat_mode),
        .clear_counts (clear_counts),
        .words_done   (words_done),
        .ovf_words    (ovf_words),
        .busy         (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: unpack each lane pair, add as integers, then pack wide or clamped.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] w, input bit sat);
        logic [DW-1:0] r;
        int a, b, s, mask;
        r = '0;
        mask = (1 << OW) - 1;
        for (int i = 0; i < LANES; i++) begin
            a = int'((w >> (2*i*OW)) & DW'(mask));
            b = int'((w >> ((2*i+1)*OW)) & DW'(mask));
            s = a + b;
            if (sat) r = r | (DW'((s > mask) ? mask : s) << (i*OW));
            else     r = r | (DW'(s) << (i*(OW+1)));
        end
        return r;
    endfunction

    function automatic bit has_ovf(input logic [DW-1:0] w);
        int mask;
        bit f;
        mask = (1 << OW) - 1;
        f = 0;
        for (int i = 0; i < LANES; i++) begin
            if (int'((w >> (2*i*OW)) & DW'(mask)) + int'((w >> ((2*i+1)*OW)) & DW'(mask)) > mask) f = 1;
        end
        return f;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w, input bit sat);
        src_t it;
        it.word = w;
        it.sat  = sat;
        src_q.push_back(it);
        pushed++;
    endtask

    function automatic bit is_idle();
        return (src_q.size() == 0) && (exp_q.size() == 0) && !pop_pending && !busy && !data_wr;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            #3;
            n++;
        end while (!is_idle() && n < budget);
        check_output({name, " idle timeout"}, 64'(is_idle()), 64'd1);
    endtask

    // Input FIFO model: present the head, pop it on the edge after data_rd was seen high.
    initial begin : driver
        src_t  hd;
        exp_t  e;
        forever begin
            @(negedge clock);
            #1;
            if (pop_pending && src_q.size() > 0) hd = src_q.pop_front();
            pop_pending = 0;
            data_full = full_rand ? ($urandom_range(0, 2) == 0) : full_hold;
            if (src_q.size() > 0) begin
                data_empty = 1'b0;
                data_din   = src_q[0].word;
                sat_mode   = src_q[0].sat;
            end else begin
                data_empty = 1'b1;
                data_din   = $urandom;
                sat_mode   = 1'($urandom);
            end
            #1;
            if (stream_chk && !data_empty && !data_rd) rd_gap++;
            if (data_rd) begin
                if (data_empty) begin
                    check_output("rd_while_empty", 64'(data_rd), 64'd0);
                end else begin
                    pop_pending = 1;
                    pops++;
                    e.data = model(src_q[0].word, src_q[0].sat);
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                    if (has_ovf(src_q[0].word)) exp_ovf++;
                end
            end
        end
    end

    // Scoreboard: every push must match the oldest outstanding pop; words_done tracks pushes.
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                exp_done = 0;
            end else begin
                if (clear_counts) exp_done = 0;
                else if (data_wr && exp_done < 65535) exp_done++;
                if (data_wr) begin
                    last_dout = data_dout;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_write", 64'(data_wr), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("data_dout", 64'(data_dout), 64'(e.data));
                        if (lat_en) check_output("latency", 64'(cyc - e.cyc), 64'd3);
                    end
                end
                check_output("words_done", 64'(words_done), 64'(exp_done));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n, p, wr_cnt;

        // Reset state, with a word already waiting so data_rd gating is visible.
        push_word(32'h8765_4321, 1'b0);
        repeat (3) @(negedge clock);
        #2;
        check_output("rst_data_wr",    64'(data_wr),    64'd0);
        check_output("rst_data_dout",  64'(data_dout),  64'd0);
        check_output("rst_words_done", 64'(words_done), 64'd0);
        check_output("rst_ovf_words",  64'(ovf_words),  64'd0);
        check_output("rst_busy",       64'(busy),       64'd0);
        check_output("rst_data_rd",    64'(data_rd),    64'd0);
        @(negedge clock);
        #1 reset_n = 1'b1;

        // Directed words with hand-computed results.
        lat_en = 1;
        wait_idle(50, "wide");
        check_output("wide_literal", 64'(last_dout), 64'h0007_ACE3);
        check_output("wide_ovf",     64'(ovf_words), 64'd0);
        check_output("wide_done",    64'(words_done), 64'd1);
        push_word(32'h8765_4321, 1'b1);
        wait_idle(50, "sat");
        check_output("sat_literal", 64'(last_dout), 64'h0000_FB73);
        push_word(32'h0000_00F1, 1'b0);
        wait_idle(50, "ovf_wide");
        check_output("ovf_wide_literal", 64'(last_dout), 64'h0000_0010);
        push_word(32'h0000_00F1, 1'b1);
        wait_idle(50, "ovf_sat");
        check_output("ovf_sat_literal", 64'(last_dout), 64'h0000_000F);
        check_output("ovf_count", 64'(ovf_words), 64'd2);
        check_output("ovf_done",  64'(words_done), 64'd4);
        check_output("model_ovf", 64'(exp_ovf), 64'd2);

        // Clear coinciding with both counter increments.
        p = pops;
        push_word(32'h0000_00F1, 1'b0);
        n = 0;
        while (pops == p && n < 20) begin @(negedge clock); #3; n++; end
        check_output("clear_pop_timeout", 64'(pops - p), 64'd1);
        p = cyc;
        n = 0;
        do begin @(negedge clock); n++; end while (cyc < p + 2 && n < 20);
        #1 clear_counts = 1'b1;
        @(negedge clock);
        #1 clear_counts = 1'b0;
        #1;
        check_output("clear_wr",   64'(data_wr),    64'd1);
        check_output("clear_done", 64'(words_done), 64'd0);
        check_output("clear_ovf",  64'(ovf_words),  64'd0);
        exp_ovf = 0;
        pushed = 0;
        wait_idle(50, "clear");
        lat_en = 0;

        // Back-pressure: output full, ten words queued.
        @(negedge clock);
        full_hold = 1;
        p = pops;
        for (int i = 0; i < 10; i++) push_word($urandom, 1'($urandom));
        repeat (14) @(negedge clock);
        #3;
        check_output("bp_pops",    64'(pops - p), 64'(DEPTH));
        check_output("bp_data_rd", 64'(data_rd),  64'd0);
        check_output("bp_busy",    64'(busy),     64'd1);
        @(negedge clock);
        full_hold = 0;
        n = 0;
        while (!data_wr && n < 20) begin @(negedge clock); #3; n++; end
        wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (data_wr) wr_cnt++;
            @(negedge clock);
            #3;
        end
        check_output("bp_back_to_back", 64'(wr_cnt), 64'd10);
        wait_idle(100, "bp");

        // Unthrottled stream: data_rd must stay high while words are available.
        rd_gap = 0;
        @(negedge clock);
        for (int i = 0; i < 30; i++) push_word($urandom, 1'($urandom));
        stream_chk = 1;
        wait_idle(200, "stream");
        stream_chk = 0;
        check_output("stream_rd_gap", 64'(rd_gap), 64'd0);

        // Plain clear pulse, then 100 random words with random back-pressure.
        @(negedge clock);
        #1 clear_counts = 1'b1;
        @(negedge clock);
        #1 clear_counts = 1'b0;
        #1;
        check_output("clr_done", 64'(words_done), 64'd0);
        check_output("clr_ovf",  64'(ovf_words),  64'd0);
        exp_ovf = 0;
        pushed = 0;
        @(negedge clock);
        full_rand = 1;
        for (int i = 0; i < 100; i++) push_word($urandom, 1'($urandom));
        wait_idle(2000, "random");
        full_rand = 0;
        full_hold = 0;
        wait_idle(20, "random_drain");
        check_output("rand_done", 64'(words_done), 64'd100);
        check_output("rand_ovf",  64'(ovf_words),  64'(exp_ovf));

        // Reset while three results are buffered and the first is leaving.
        @(negedge clock);
        full_hold = 1;
        for (int i = 0; i < 3; i++) push_word($urandom | 32'h0000_000F, 1'b0);
        repeat (8) @(negedge clock);
        #3;
        check_output("mid_busy_before", 64'(busy), 64'd1);
        @(negedge clock);
        full_hold = 0;
        @(posedge clock);
        #2;
        check_output("mid_wr_before", 64'(data_wr), 64'd1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("mid_wr_drop", 64'(data_wr),    64'd0);
        check_output("mid_done",    64'(words_done), 64'd0);
        check_output("mid_ovf",     64'(ovf_words),  64'd0);
        check_output("mid_busy",    64'(busy),       64'd0);
        check_output("mid_rd",      64'(data_rd),    64'd0);
        exp_ovf = 0;
        pushed = 0;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (10) @(negedge clock);
        #3;
        check_output("post_rst_busy", 64'(busy),       64'd0);
        check_output("post_rst_done", 64'(words_done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
